// File: rtl/keypad_scanner_if.sv
// Keypad-side and lock-side signals of the keypad scanner, bundled for port connection.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [3:0] Code_1;
  logic       Valid_1;
  logic       key_held;

  modport slave (
    output row_n,
    output Code_1,
    output Valid_1,
    output key_held,
    input  col_n
  );

  modport master (
    input  row_n,
    input  Code_1,
    input  Valid_1,
    input  key_held,
    output col_n
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row scan, column sync, press/release debounce, key encoding.
// Optional auto-repeat while held is built when KEY_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_TICKS  = 10
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 20
`endif
) (
  input  logic             clk,
  input  logic             reset_1,
  keypad_scanner_if.slave  kp
);

  localparam int              DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]      DEB_LIM = DEB_TICKS[7:0];

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_col_meta;
  logic [2:0]       r_col_s;
  logic [2:0]       r_col_lat;
  logic [1:0]       r_row;
  logic [3:0]       r_row_n;
  logic [7:0]       r_deb;
  logic [3:0]       r_code;
  logic             r_valid;
  logic             r_held;

  logic             w_tick;
  logic             w_one_low;
  logic             w_all_high;
  logic [1:0]       w_row_nxt;
  logic [3:0]       w_row_n_nxt;
  logic [7:0]       w_deb_inc;
  logic [7:0]       w_deb_sat;
  logic             w_rep_fire;

  assign w_tick      = (r_div == DIV_MAX);
  assign w_all_high  = (r_col_s == 3'b111);
  assign w_one_low   = (r_col_s == 3'b110) || (r_col_s == 3'b101) || (r_col_s == 3'b011);
  assign w_row_nxt   = r_row + 2'd1;
  assign w_row_n_nxt = ~(4'b0001 << w_row_nxt);
  assign w_deb_inc   = r_deb + 8'd1;
  assign w_deb_sat   = (r_deb == 8'hFF) ? r_deb : w_deb_inc;

  assign kp.row_n    = r_row_n;
  assign kp.Code_1   = r_code;
  assign kp.Valid_1  = r_valid;
  assign kp.key_held = r_held;

  function automatic logic [3:0] f_code(input logic [1:0] row, input logic [2:0] cols);
    logic [1:0] c;
    c = (cols == 3'b110) ? 2'd0 : ((cols == 3'b101) ? 2'd1 : 2'd2);
    if (row == 2'd3) begin
      case (c)
        2'd0:    f_code = 4'd10;
        2'd1:    f_code = 4'd0;
        default: f_code = 4'd11;
      endcase
    end else begin
      f_code = {2'b00, row} * 4'd3 + {2'b00, c} + 4'd1;
    end
  endfunction

  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Columns float asynchronously relative to clk; idle (pulled-up) value on reset.
  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      r_col_meta <= 3'b111;
      r_col_s    <= 3'b111;
    end else begin
      r_col_meta <= kp.col_n;
      r_col_s    <= r_col_meta;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam logic [15:0] REP_DLY = REPEAT_DLY[15:0];
  localparam logic [15:0] REP_PER = REPEAT_PER[15:0];

  logic [15:0] r_rep;
  logic        r_rep_armed;
  logic [15:0] w_rep_inc;
  logic        w_rep_step;

  assign w_rep_inc  = r_rep + 16'd1;
  assign w_rep_step = (r_state == HELD) && w_tick && !w_all_high;
  assign w_rep_fire = w_rep_step && (w_rep_inc == (r_rep_armed ? REP_PER : REP_DLY));

  // Counts only HELD ticks, so time spent in DEB_REL pauses it rather than resetting it.
  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      r_rep       <= '0;
      r_rep_armed <= 1'b0;
    end else if (r_state == DEB_PRESS) begin
      r_rep       <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_rep_step) begin
      if (w_rep_fire) begin
        r_rep       <= '0;
        r_rep_armed <= 1'b1;
      end else if (r_rep != 16'hFFFF) begin
        r_rep <= w_rep_inc;
      end
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      r_state   <= SCAN;
      r_col_lat <= 3'b111;
      r_row     <= 2'd0;
      r_row_n   <= 4'b1110;
      r_deb     <= 8'd0;
      r_code    <= 4'b0000;
      r_valid   <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          SCAN: begin
            if (w_one_low) begin
              r_col_lat <= r_col_s;
              r_deb     <= 8'd0;
              r_state   <= DEB_PRESS;
            end else begin
              r_row   <= w_row_nxt;
              r_row_n <= w_row_n_nxt;
            end
          end
          DEB_PRESS: begin
            if (r_col_s == r_col_lat) begin
              r_deb <= w_deb_sat;
              if (w_deb_inc == DEB_LIM) begin
                r_code  <= f_code(r_row, r_col_lat);
                r_valid <= 1'b1;
                r_held  <= 1'b1;
                r_state <= HELD;
              end
            end else begin
              r_state <= SCAN;
            end
          end
          HELD: begin
            if (w_all_high) begin
              r_deb   <= 8'd0;
              r_state <= DEB_REL;
            end else if (w_rep_fire) begin
              r_valid <= 1'b1;
            end
          end
          DEB_REL: begin
            if (w_all_high) begin
              r_deb <= w_deb_sat;
              if (w_deb_inc == DEB_LIM) begin
                r_held  <= 1'b0;
                r_state <= SCAN;
                r_row   <= w_row_nxt;
                r_row_n <= w_row_n_nxt;
              end
            end else begin
              r_state <= HELD;
            end
          end
          default: r_state <= SCAN;
        endcase
      end
    end
  end

endmodule
